// File: rtl/hdmi_pll_ctrl.sv
// hdmi_pll_ctrl: sequencer for the HDMI serial-clock rPLL, clocked by the free-running board clock.
// Loads divider codes for the selected mode, pulses the PLL reset, qualifies LOCK, releases the
// TMDS/serializer reset, and re-sequences on lock loss, mode change or lock timeout (bounded retries).
// Ports:
//   clk, rst_n           reference clock (also PLL CLKIN), async active-low reset
//   mode_sel, mode_req   requested mode, one-cycle request to apply it and re-sequence
//   pll_lock             raw PLL LOCK (asynchronous, synchronized internally)
//   pll_reset            rPLL RESET, active high
//   idsel/fbdsel/odsel   rPLL dynamic divider codes
//   tx_rst_n, ready      downstream reset release / qualified lock (identical)
//   fail                 retries exhausted, held until mode_req or rst_n
//   mode_cur             mode loaded into the dividers
//   retry_cnt, loss_cnt  consecutive timeouts, lock-loss events in RUN (saturating)
module hdmi_pll_ctrl #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned LOCK_TIMEOUT = 500000,
  parameter int unsigned MAX_RETRY    = 3,
  parameter logic [5:0]  M0_IDSEL     = 6'd0,
  parameter logic [5:0]  M0_FBDSEL    = 6'd4,
  parameter logic [5:0]  M0_ODSEL     = 6'd4,
  parameter logic [5:0]  M1_IDSEL     = 6'd0,
  parameter logic [5:0]  M1_FBDSEL    = 6'd14,
  parameter logic [5:0]  M1_ODSEL     = 6'd2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode_sel,
  input  logic       mode_req,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [5:0] idsel,
  output logic [5:0] fbdsel,
  output logic [5:0] odsel,
  output logic       tx_rst_n,
  output logic       ready,
  output logic       fail,
  output logic       mode_cur,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  localparam int unsigned MAX_AB = (RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE;
  localparam int unsigned MAX_P  = (MAX_AB > LOCK_TIMEOUT) ? MAX_AB : LOCK_TIMEOUT;
  localparam int unsigned CNT_W  = $clog2(MAX_P + 1);

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [CNT_W-1:0]   stb_cnt_q, stb_cnt_d;
  logic [3:0]         retry_q, retry_d;
  logic [7:0]         loss_q, loss_d;
  logic               mode_q, mode_d;
  logic [5:0]         idsel_q, idsel_d;
  logic [5:0]         fbdsel_q, fbdsel_d;
  logic [5:0]         odsel_q, odsel_d;
  logic               pll_reset_q, pll_reset_d;
  logic               tx_rst_n_q, tx_rst_n_d;
  logic               ready_q, ready_d;
  logic               fail_q, fail_d;
  logic               lock_meta_q, lock_s_q;
  logic               lost_in_run;
  logic               enter_reset;

  // Two-flop synchronizer for the asynchronous LOCK output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= pll_lock;
      lock_s_q    <= lock_meta_q;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RESET;
      rst_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      stb_cnt_q   <= '0;
      retry_q     <= 4'd0;
      loss_q      <= 8'd0;
      mode_q      <= 1'b0;
      idsel_q     <= M0_IDSEL;
      fbdsel_q    <= M0_FBDSEL;
      odsel_q     <= M0_ODSEL;
      pll_reset_q <= 1'b1;
      tx_rst_n_q  <= 1'b0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      stb_cnt_q   <= stb_cnt_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      mode_q      <= mode_d;
      idsel_q     <= idsel_d;
      fbdsel_q    <= fbdsel_d;
      odsel_q     <= odsel_d;
      pll_reset_q <= pll_reset_d;
      tx_rst_n_q  <= tx_rst_n_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
    end
  end

  // Next-state, counter and output decode.
  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = '0;
    tmo_cnt_d   = '0;
    stb_cnt_d   = '0;
    retry_d     = retry_q;
    loss_d      = loss_q;
    mode_d      = mode_q;
    idsel_d     = idsel_q;
    fbdsel_d    = fbdsel_q;
    odsel_d     = odsel_q;

    // Lock loss is counted even when a coincident mode_req takes priority.
    lost_in_run = (state_q == S_RUN) && !lock_s_q;
    if (lost_in_run && (loss_q != 8'hFF)) begin
      loss_d = loss_q + 8'd1;
    end

    if (mode_req) begin
      mode_d  = mode_sel;
      retry_d = 4'd0;
      state_d = S_RESET;
    end else begin
      case (state_q)
        S_RESET: begin
          if (rst_cnt_q == CNT_W'(RST_CYCLES - 1)) state_d = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (lock_s_q) begin
            state_d = S_STABLE;
          end else if (tmo_cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
            retry_d = retry_q + 4'd1;
            state_d = (retry_d == 4'(MAX_RETRY)) ? S_FAIL : S_RESET;
          end
        end
        S_STABLE: begin
          if (!lock_s_q) begin
            state_d = S_WAIT_LOCK;
          end else if (stb_cnt_q >= CNT_W'(LOCK_STABLE - 1)) begin
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (!lock_s_q) state_d = S_RESET;
        end
        S_FAIL: begin
          state_d = S_FAIL;
        end
        default: begin
          state_d = S_RESET;
        end
      endcase
    end

    // RESET pulse counter restarts on every entry, including a mode_req while already in RESET.
    enter_reset = (state_d == S_RESET) && ((state_q != S_RESET) || mode_req);
    if ((state_d == S_RESET) && !enter_reset) begin
      rst_cnt_d = rst_cnt_q + CNT_W'(1);
    end

    // Timeout counter starts fresh from RESET, pauses in STABLE, resumes after a lock glitch.
    if (state_d == S_WAIT_LOCK) begin
      if (state_q == S_WAIT_LOCK)   tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
      else if (state_q == S_STABLE) tmo_cnt_d = tmo_cnt_q;
    end else if (state_d == S_STABLE) begin
      tmo_cnt_d = tmo_cnt_q;
    end

    // The WAIT_LOCK cycle that saw lock_s=1 counts as the first stable cycle.
    if (state_d == S_STABLE) begin
      stb_cnt_d = (state_q == S_STABLE) ? stb_cnt_q + CNT_W'(1) : CNT_W'(1);
    end

    if ((state_d == S_RUN) && (state_q != S_RUN)) begin
      retry_d = 4'd0;
    end

    // Dividers only move on RESET entry, taking the (possibly new) mode's codes.
    if (enter_reset) begin
      idsel_d  = mode_d ? M1_IDSEL  : M0_IDSEL;
      fbdsel_d = mode_d ? M1_FBDSEL : M0_FBDSEL;
      odsel_d  = mode_d ? M1_ODSEL  : M0_ODSEL;
    end

    pll_reset_d = (state_d == S_RESET) || (state_d == S_FAIL);
    tx_rst_n_d  = (state_d == S_RUN);
    ready_d     = (state_d == S_RUN);
    fail_d      = (state_d == S_FAIL);
  end

  assign pll_reset = pll_reset_q;
  assign idsel     = idsel_q;
  assign fbdsel    = fbdsel_q;
  assign odsel     = odsel_q;
  assign tx_rst_n  = tx_rst_n_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign mode_cur  = mode_q;
  assign retry_cnt = retry_q;
  assign loss_cnt  = loss_q;

endmodule

// File: tb/tb_hdmi_pll_ctrl.sv
// tb_hdmi_pll_ctrl: directed bench for hdmi_pll_ctrl with small sequencing parameters.
module tb_hdmi_pll_ctrl;

  logic       clk;
  logic       rst_n;
  logic       mode_sel;
  logic       mode_req;
  logic       pll_lock;
  logic       pll_reset;
  logic [5:0] idsel;
  logic [5:0] fbdsel;
  logic [5:0] odsel;
  logic       tx_rst_n;
  logic       ready;
  logic       fail;
  logic       mode_cur;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;

  int   n_cmp;
  int   n_err;
  logic saw_rst;

  hdmi_pll_ctrl #(
    .RST_CYCLES  (4),
    .LOCK_STABLE (8),
    .LOCK_TIMEOUT(32),
    .MAX_RETRY   (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode_sel (mode_sel),
    .mode_req (mode_req),
    .pll_lock (pll_lock),
    .pll_reset(pll_reset),
    .idsel    (idsel),
    .fbdsel   (fbdsel),
    .odsel    (odsel),
    .tx_rst_n (tx_rst_n),
    .ready    (ready),
    .fail     (fail),
    .mode_cur (mode_cur),
    .retry_cnt(retry_cnt),
    .loss_cnt (loss_cnt)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance n clock edges; outputs are then observed 1 ns after the edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (pll_reset) saw_rst = 1'b1;
    end
  endtask

  task automatic chk_div(input string tag, input logic [5:0] id, input logic [5:0] fb,
                         input logic [5:0] od);
    chk({tag, "_idsel"},  32'(idsel),  32'(id));
    chk({tag, "_fbdsel"}, 32'(fbdsel), 32'(fb));
    chk({tag, "_odsel"},  32'(odsel),  32'(od));
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    saw_rst  = 1'b0;
    rst_n    = 1'b0;
    pll_lock = 1'b0;
    mode_req = 1'b0;
    mode_sel = 1'b0;

    // Reset state
    tick(3);
    chk("rst_pll_reset", 32'(pll_reset), 32'd1);
    chk("rst_tx_rst_n",  32'(tx_rst_n),  32'd0);
    chk("rst_ready",     32'(ready),     32'd0);
    chk("rst_fail",      32'(fail),      32'd0);
    chk("rst_mode_cur",  32'(mode_cur),  32'd0);
    chk("rst_retry",     32'(retry_cnt), 32'd0);
    chk("rst_loss",      32'(loss_cnt),  32'd0);
    chk_div("rst", 6'd0, 6'd4, 6'd4);

    // Power-up: pll_reset high for cycles 0-3, lock raised at cycle 10
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pu_pll_reset_c%0d", i), 32'(pll_reset), 32'd1);
      tick(1);
    end
    chk("pu_pll_reset_rel", 32'(pll_reset), 32'd0);
    tick(6);
    pll_lock = 1'b1;
    tick(9);
    chk("pu_ready_early", 32'(ready), 32'd0);
    tick(1);
    chk("pu_ready",    32'(ready),    32'd1);
    chk("pu_tx_rst_n", 32'(tx_rst_n), 32'd1);
    chk("pu_retry",    32'(retry_cnt), 32'd0);
    chk_div("pu", 6'd0, 6'd4, 6'd4);

    // Lock dropped in RUN: reset follows 3 cycles later, 4 cycles wide
    pll_lock = 1'b0;
    tick(2);
    chk("drop_ready_hold", 32'(ready), 32'd1);
    tick(1);
    chk("drop_tx_rst_n",  32'(tx_rst_n),  32'd0);
    chk("drop_ready",     32'(ready),     32'd0);
    chk("drop_pll_reset", 32'(pll_reset), 32'd1);
    chk("drop_loss",      32'(loss_cnt),  32'd1);
    for (int i = 1; i < 4; i++) begin
      tick(1);
      chk($sformatf("drop_pll_reset_c%0d", i), 32'(pll_reset), 32'd1);
    end
    tick(1);
    chk("drop_pll_reset_rel", 32'(pll_reset), 32'd0);

    // Relock with a one-cycle glitch during STABLE: RUN six cycles later, no reset pulse
    saw_rst  = 1'b0;
    pll_lock = 1'b1;
    tick(5);
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    tick(9);
    chk("glitch_ready_early", 32'(ready), 32'd0);
    tick(1);
    chk("glitch_ready",  32'(ready),     32'd1);
    chk("glitch_no_rst", 32'(saw_rst),   32'd0);
    chk("glitch_retry",  32'(retry_cnt), 32'd0);
    chk("glitch_loss",   32'(loss_cnt),  32'd1);

    // Lock held low: two 32-cycle timeouts then FAIL
    pll_lock = 1'b0;
    tick(38);
    chk("tmo1_pre_retry", 32'(retry_cnt), 32'd0);
    chk("tmo1_pre_reset", 32'(pll_reset), 32'd0);
    chk("tmo_loss",       32'(loss_cnt),  32'd2);
    tick(1);
    chk("tmo1_retry", 32'(retry_cnt), 32'd1);
    chk("tmo1_reset", 32'(pll_reset), 32'd1);
    tick(35);
    chk("tmo2_pre_retry", 32'(retry_cnt), 32'd1);
    chk("tmo2_pre_fail",  32'(fail),      32'd0);
    chk("tmo2_pre_reset", 32'(pll_reset), 32'd0);
    tick(1);
    chk("tmo2_retry", 32'(retry_cnt), 32'd2);
    chk("tmo2_fail",  32'(fail),      32'd1);
    chk("tmo2_reset", 32'(pll_reset), 32'd1);
    tick(40);
    chk("fail_stuck",       32'(fail),      32'd1);
    chk("fail_reset_stuck", 32'(pll_reset), 32'd1);
    chk("fail_tx_rst_n",    32'(tx_rst_n),  32'd0);

    // mode_req to mode 1 leaves FAIL with new dividers
    mode_sel = 1'b1;
    mode_req = 1'b1;
    tick(1);
    mode_req = 1'b0;
    mode_sel = 1'b0;
    chk("m1_fail",      32'(fail),      32'd0);
    chk("m1_retry",     32'(retry_cnt), 32'd0);
    chk("m1_mode_cur",  32'(mode_cur),  32'd1);
    chk("m1_pll_reset", 32'(pll_reset), 32'd1);
    chk_div("m1", 6'd0, 6'd14, 6'd2);
    tick(3);
    chk("m1_pll_reset_c3", 32'(pll_reset), 32'd1);
    tick(1);
    chk("m1_pll_reset_rel", 32'(pll_reset), 32'd0);
    chk_div("m1_wait", 6'd0, 6'd14, 6'd2);

    // mode_req during WAIT_LOCK back to mode 0
    tick(5);
    mode_sel = 1'b0;
    mode_req = 1'b1;
    tick(1);
    mode_req = 1'b0;
    chk("mw_pll_reset", 32'(pll_reset), 32'd1);
    chk("mw_mode_cur",  32'(mode_cur),  32'd0);
    chk("mw_loss",      32'(loss_cnt),  32'd2);
    chk_div("mw", 6'd0, 6'd4, 6'd4);
    tick(3);
    chk("mw_pll_reset_c3", 32'(pll_reset), 32'd1);
    tick(1);
    chk("mw_pll_reset_rel", 32'(pll_reset), 32'd0);
    pll_lock = 1'b1;
    tick(10);
    chk("mw_ready", 32'(ready), 32'd1);

    // mode_req coincident with lock loss in RUN
    pll_lock = 1'b0;
    tick(2);
    mode_sel = 1'b1;
    mode_req = 1'b1;
    tick(1);
    mode_req = 1'b0;
    mode_sel = 1'b0;
    chk("mc_pll_reset", 32'(pll_reset), 32'd1);
    chk("mc_ready",     32'(ready),     32'd0);
    chk("mc_mode_cur",  32'(mode_cur),  32'd1);
    chk("mc_loss",      32'(loss_cnt),  32'd3);
    chk_div("mc", 6'd0, 6'd14, 6'd2);

    // Asynchronous reset while in STABLE
    tick(4);
    chk("ar_pll_reset_rel", 32'(pll_reset), 32'd0);
    pll_lock = 1'b1;
    tick(4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_pll_reset", 32'(pll_reset), 32'd1);
    chk("ar_tx_rst_n",  32'(tx_rst_n),  32'd0);
    chk("ar_ready",     32'(ready),     32'd0);
    chk("ar_fail",      32'(fail),      32'd0);
    chk("ar_mode_cur",  32'(mode_cur),  32'd0);
    chk("ar_retry",     32'(retry_cnt), 32'd0);
    chk("ar_loss",      32'(loss_cnt),  32'd0);
    chk_div("ar", 6'd0, 6'd4, 6'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
